usb_ulpi_tx: RTL and testbench



---
 rtl/usb_pkg.sv | 38 +++
 rtl/usb_crc16.sv | 47 ++++
 rtl/usb_ulpi_tx.sv | 193 +++++++++++++++++++
 tb/tb_usb_ulpi_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB/ULPI definitions for the host transmit path.
// Build option: USB_TX_CRC16_EN adds the CRC16 states and the DATA-PID helper.
package usb_pkg;

   // USB PIDs, low-nibble form
   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_SETUP = 4'hD;

   // ULPI TXCMD upper nibble for a transmit packet
   localparam logic [3:0] ULPI_TXCMD_PKT = 4'b0100;

   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StTxcmd,
      StData,
`ifdef USB_TX_CRC16_EN
      StCrcLo,
      StCrcHi,
`endif
      StStop,
      StAbort,
      StAbortWait
   } tx_state_e;

`ifdef USB_TX_CRC16_EN
   // DATA0/DATA1/DATA2/MDATA all have the two low PID bits set
   function automatic logic is_data_pid(input logic [3:0] pid);
      return pid[1:0] == 2'b11;
   endfunction
`endif

endpackage

// File: rtl/usb_crc16.sv
// USB CRC16 accumulator: reflected poly 0x8005, init 0xFFFF, complemented output.
// Only instantiated when USB_TX_CRC16_EN is defined.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   // Fold one byte in, LSB first; 0xA001 is 0x8005 bit-reversed
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i]) begin
            c = (c >> 1) ^ 16'hA001;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   // Next remainder for the byte on data_i
   always_comb begin
      crc_d = crc16_byte(crc_q, data_i);
   end

   // Remainder register; clear wins over enable
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         crc_q <= CRC16_INIT;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = ~crc_q;

endmodule

// File: rtl/usb_ulpi_tx.sv
// ULPI link-side transmit engine: TXCMD, nxt-paced payload, stp termination.
// Build option: USB_TX_CRC16_EN appends a CRC16 to DATA PIDs; without it the
// caller supplies the CRC bytes inside the payload.
module usb_ulpi_tx
   import usb_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 8,
   parameter int unsigned LEN_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dir_i,
   input  logic                   nxt_i,
   output logic [7:0]             data_o,
   output logic                   stp_o,
   input  logic                   tx_valid_i,
   output logic                   tx_ready_o,
   input  logic [3:0]             tx_pid_i,
   input  logic [LEN_W-1:0]       tx_len_i,
   input  logic [8*MAX_BYTES-1:0] tx_data_i,
   output logic                   tx_done_o,
   output logic                   tx_abort_o
);

   localparam int unsigned      DataW  = 8 * MAX_BYTES;
   localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BYTES);

   tx_state_e        state_q, state_d;
   tx_state_e        post_payload;
   logic [3:0]       pid_q, pid_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] cnt_inc;
   logic [LEN_W-1:0] len_clamped;
   logic [DataW-1:0] data_q, data_d;
   logic             dir_q;
   logic             accept;
   logic             byte_ack;
   logic [7:0]       cur_byte;

   // Payload is kept as a shift register: the byte on the bus is always the top one
   assign cur_byte    = data_q[DataW-1 -: 8];
   assign len_clamped = (tx_len_i > MaxLen) ? MaxLen : tx_len_i;
   assign cnt_inc     = cnt_q + LEN_W'(1);
   // dir has priority over nxt: a byte is only taken while the link owns the bus
   assign byte_ack    = nxt_i & ~dir_i;

`ifdef USB_TX_CRC16_EN
   logic [15:0] crc_val;
   logic        crc_en;

   assign crc_en = (state_q == StData) && byte_ack;

   usb_crc16 u_crc16 (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .en_i   (crc_en),
      .data_i (cur_byte),
      .crc_o  (crc_val)
   );

   assign post_payload = is_data_pid(pid_q) ? StCrcLo : StStop;
`else
   assign post_payload = StStop;
`endif

   // Next state, request latching and bus outputs
   always_comb begin
      state_d    = state_q;
      pid_d      = pid_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      data_o     = 8'h00;
      stp_o      = 1'b0;
      tx_done_o  = 1'b0;
      tx_abort_o = 1'b0;

      // dir_q high means dir just fell: that cycle is the bus turnaround
      tx_ready_o = (state_q == StIdle) && !dir_i && !dir_q && !rst;
      accept     = tx_valid_i && tx_ready_o;

      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StTxcmd;
               pid_d   = tx_pid_i;
               len_d   = len_clamped;
               data_d  = tx_data_i;
               cnt_d   = '0;
            end
         end

         StTxcmd: begin
            data_o = {ULPI_TXCMD_PKT, pid_q};
            if (dir_i) begin
               state_d = StAbort;
            end else if (nxt_i) begin
               state_d = (len_q != '0) ? StData : post_payload;
            end
         end

         StData: begin
            data_o = cur_byte;
            if (dir_i) begin
               state_d = StAbort;
            end else if (nxt_i) begin
               data_d = {data_q[DataW-9:0], 8'h00};
               cnt_d  = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = post_payload;
               end
            end
         end

`ifdef USB_TX_CRC16_EN
         StCrcLo: begin
            data_o = crc_val[7:0];
            if (dir_i) begin
               state_d = StAbort;
            end else if (nxt_i) begin
               state_d = StCrcHi;
            end
         end

         StCrcHi: begin
            data_o = crc_val[15:8];
            if (dir_i) begin
               state_d = StAbort;
            end else if (nxt_i) begin
               state_d = StStop;
            end
         end
`endif

         StStop: begin
            stp_o     = 1'b1;
            tx_done_o = 1'b1;
            state_d   = StIdle;
         end

         // First abort cycle carries the pulse; a dir already low here is the turnaround
         StAbort: begin
            tx_abort_o = 1'b1;
            state_d    = dir_i ? StAbortWait : StIdle;
         end

         StAbortWait: begin
            if (!dir_i) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      // Keep the bus idle and suppress pulses while reset is held
      if (rst) begin
         data_o     = 8'h00;
         stp_o      = 1'b0;
         tx_done_o  = 1'b0;
         tx_abort_o = 1'b0;
      end
   end

   // FSM and request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pid_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pid_q   <= pid_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Previous dir, used to detect the falling edge for turnaround
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir_i;
      end
   end

endmodule

// File: tb/tb_usb_ulpi_tx.sv
// Bench for usb_ulpi_tx: directed packets from the test plan plus random
// packets, aborts and resets, checked against a byte-stream model.
module tb_usb_ulpi_tx;
   import usb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dir;
   logic        nxt;
   logic [7:0]  data;
   logic        stp;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  tx_pid;
   logic [3:0]  tx_len;
   logic [63:0] tx_data;
   logic        tx_done;
   logic        tx_abort;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   usb_ulpi_tx dut (
      .clk        (clk),
      .rst        (rst),
      .dir_i      (dir),
      .nxt_i      (nxt),
      .data_o     (data),
      .stp_o      (stp),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .tx_pid_i   (tx_pid),
      .tx_len_i   (tx_len),
      .tx_data_i  (tx_data),
      .tx_done_o  (tx_done),
      .tx_abort_o (tx_abort)
   );

   task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag, input logic ready);
      chk_d({tag, "_data"}, data, 8'h00);
      chk_b({tag, "_stp"}, stp, 1'b0);
      chk_b({tag, "_done"}, tx_done, 1'b0);
      chk_b({tag, "_abort"}, tx_abort, 1'b0);
      chk_b({tag, "_ready"}, tx_ready, ready);
   endtask

   // Model: the bus shows byte k of [TXCMD, payload, (CRC)] until nxt takes it;
   // after the last byte comes one stp cycle. ev_at picks the byte index where
   // dir rises (ev_rst=0) or rst is applied (ev_rst=1); -1 means none.
   task automatic send(input logic [3:0] pid, input logic [3:0] len, input logic [63:0] pay,
                       input int stall_idx, input int stall_n, input int rnd_pct,
                       input int ev_at, input bit ev_rst);
      logic [7:0] exp_q[$];
      int nl, n, k, st, ev, h;
      bit nx;
      nl = (len > 4'd8) ? 8 : int'(len);
      exp_q = {};
      exp_q.push_back({4'b0100, pid});
      for (int i = 0; i < nl; i++) exp_q.push_back(pay[63-8*i -: 8]);
`ifdef USB_TX_CRC16_EN
      if (pid[1:0] == 2'b11) begin
         logic [15:0] crc;
         crc = 16'hFFFF;
         for (int i = 0; i < nl; i++) begin
            for (int j = 0; j < 8; j++) begin
               if (crc[0] ^ pay[63-8*i+j]) crc = (crc >> 1) ^ 16'hA001;
               else crc = crc >> 1;
            end
         end
         crc = ~crc;
         exp_q.push_back(crc[7:0]);
         exp_q.push_back(crc[15:8]);
      end
`endif
      n  = exp_q.size();
      ev = (ev_at >= 0) ? (ev_at % n) : -1;

      tx_valid = 1'b1; tx_pid = pid; tx_len = len; tx_data = pay;
      nxt = 1'b0; dir = 1'b0;
      @(negedge clk);
      chk_b("accept_ready", tx_ready, 1'b1);
      next_cycle();
      // inputs are don't-care after acceptance
      tx_valid = 1'b0; tx_pid = 4'($urandom); tx_len = 4'($urandom);
      tx_data = {$urandom, $urandom};

      k = 0; st = 0;
      while (1) begin
         if (k == ev) break;
         if (k == stall_idx && st < stall_n) begin
            nx = 1'b0; st++;
         end else begin
            nx = ($urandom_range(0, 99) >= rnd_pct);
         end
         nxt = nx;
         @(negedge clk);
         chk_d("pkt_data", data, (k < n) ? exp_q[k] : 8'h00);
         chk_b("pkt_stp", stp, k == n);
         chk_b("pkt_done", tx_done, k == n);
         chk_b("pkt_abort", tx_abort, 1'b0);
         chk_b("pkt_ready", tx_ready, 1'b0);
         next_cycle();
         if (k == n) break;
         if (nx) k++;
      end

      if (ev < 0) begin
         nxt = 1'b0;
         @(negedge clk);
         chk_idle("post_done", 1'b1);
         next_cycle();
      end else if (!ev_rst) begin
         // dir rises together with a random nxt: dir must win
         dir = 1'b1; nxt = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_d("dirrise_data", data, exp_q[k]);
         chk_b("dirrise_done", tx_done, 1'b0);
         next_cycle();
         h = $urandom_range(1, 3);
         for (int j = 1; j <= h; j++) begin
            dir = (j < h); nxt = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_d("abort_data", data, 8'h00);
            chk_b("abort_stp", stp, 1'b0);
            chk_b("abort_done", tx_done, 1'b0);
            chk_b("abort_pulse", tx_abort, j == 1);
            chk_b("abort_ready", tx_ready, 1'b0);
            next_cycle();
         end
         dir = 1'b0; nxt = 1'b0;
         @(negedge clk);
         chk_idle("post_abort", 1'b1);
         next_cycle();
      end else begin
         rst = 1'b1; nxt = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_b("rst_ready", tx_ready, 1'b0);
         chk_b("rst_done", tx_done, 1'b0);
         chk_b("rst_abort", tx_abort, 1'b0);
         next_cycle();
         @(negedge clk);
         chk_idle("rst_hold", 1'b0);
         next_cycle();
         rst = 1'b0; nxt = 1'b0;
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk_idle("post_rst", 1'b1);
            next_cycle();
         end
      end
   endtask

   initial begin
      rst = 1'b1; dir = 1'b0; nxt = 1'b0; tx_valid = 1'b0;
      tx_pid = 4'h0; tx_len = 4'h0; tx_data = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_b("reset_ready", tx_ready, 1'b0);
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      chk_idle("reset_out", 1'b1);
      next_cycle();

      // ACK, TXCMD held until nxt on its third cycle
      send(PID_ACK, 4'd0, 64'h0, 0, 2, 0, -1, 1'b0);
      // IN token with two bytes, nxt always high
      send(PID_IN, 4'd2, {8'h81, 8'h58, 48'h0}, -1, 0, 0, -1, 1'b0);
      // DATA0, nxt low for two cycles on byte 0x22
      send(PID_DATA0, 4'd3, {8'h11, 8'h22, 8'h33, 40'h0}, 2, 2, 0, -1, 1'b0);
      // DATA1 with empty payload (CRC bytes only when the feature is built)
      send(PID_DATA1, 4'd0, 64'h0, -1, 0, 0, -1, 1'b0);
      // dir rises during a 4-byte DATA0
      send(PID_DATA0, 4'd4, 64'hA1B2_C3D4_0000_0000, -1, 0, 0, 2, 1'b0);
      // reset in the middle of a DATA0 payload
      send(PID_DATA0, 4'd4, 64'h0102_0304_0000_0000, -1, 0, 0, 3, 1'b1);
      // over-length request is clamped to eight bytes
      send(PID_OUT, 4'd12, 64'h0011_2233_4455_6677, -1, 0, 20, -1, 1'b0);
      send(PID_SETUP, 4'd8, 64'hFEDC_BA98_7654_3210, -1, 0, 30, -1, 1'b0);

      // dir high in IDLE blocks acceptance; falling edge costs one cycle
      tx_valid = 1'b1; tx_pid = PID_ACK; tx_len = 4'd0; dir = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_idle("idle_dir", 1'b0);
         next_cycle();
      end
      dir = 1'b0; tx_valid = 1'b0;
      @(negedge clk);
      chk_idle("idle_turn", 1'b0);
      next_cycle();
      @(negedge clk);
      chk_idle("idle_back", 1'b1);
      next_cycle();

      for (int p = 0; p < 40; p++) begin
         int r, ev;
         r  = int'($urandom_range(0, 9));
         ev = (r < 3) ? int'($urandom_range(0, 15)) : -1;
         send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
              -1, 0, int'($urandom_range(0, 60)), ev, r == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
